tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
Four-channel tick scheduler sharing one prescaler. The prescaler divides clk down to a base tick. Each channel counts base ticks against its own programmed period and emits a one-cycle tick pulse plus a toggling square output. A run/stop/single-step FSM sequences the prescaler, and a valid/ready config port programs the channels. The block replaces per-feature free-running dividers in lab top levels (LED blink, display scan, debounce sampling).

Parameters:
PRESCALE, 25000000, clk cycles per base tick (must be >= 2)
PRE_W, 25, prescaler counter width (2^PRE_W > PRESCALE-1)
PER_W, 8, channel period width, in base ticks

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  level/pulse; requests RUN
stop  in  1  level/pulse; requests IDLE
step  in  1  in IDLE, forces one base tick
cfg_valid  in  1  config write request
cfg_ready  out  1  config port can accept
cfg_ch  in  2  target channel
cfg_en  in  1  channel enable
cfg_period  in  PER_W  channel period in base ticks
running  out  1  FSM in RUN
base_tick  out  1  registered base tick pulse
tick  out  4  per-channel one-cycle pulse
sq  out  4  per-channel square wave, toggles on each tick

Behaviour:
- Reset (async, rst=1): state=IDLE, pre_cnt=0, all ch_cnt=0, all en=0, all period=0, tick=0, sq=0, base_tick=0, running=0, cfg_ready=1.
- FSM states: IDLE, RUN.
  - IDLE: start=1 and stop=0 -> RUN.
  - RUN: stop=1 -> IDLE. start in RUN is ignored.
  - start and stop in the same cycle: stop wins in either state.
  - running is registered; it equals (state==RUN).
- Prescaler:
  - In RUN, pre_cnt increments each cycle and wraps PRESCALE-1 -> 0.
  - Internal strobe bt = (state==RUN && pre_cnt==PRESCALE-1).
  - Leaving RUN clears pre_cnt to 0. In IDLE, pre_cnt holds at 0.
- Single step: in IDLE, step=1 sets bt=1 for that cycle; pre_cnt is unaffected. step is ignored in RUN. step in the same cycle as start: the step is applied, then the FSM enters RUN.
- base_tick output = bt registered (1-cycle latency).
- Channel i on bt, when en[i]=1 and period[i]!=0:
  - if ch_cnt[i]==period[i]-1: ch_cnt[i]<=0, tick[i]<=1, sq[i]<=~sq[i];
  - else ch_cnt[i]<=ch_cnt[i]+1.
  - tick is high for exactly one clk, in the cycle after the qualifying bt.
  - period=0 behaves as disabled.
  - period=1 gives a tick on every base tick.
- Disabled channel: ch_cnt, sq and tick hold at their last values, except tick, which is 0 whenever no pulse is due.
- Stop mid-count: channel counters hold, so the next RUN resumes the phase. The prescaler phase restarts from 0.
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready.
  - On acceptance: period[ch]<=cfg_period, en[ch]<=cfg_en, ch_cnt[ch]<=0, sq[ch]<=0, and cfg_ready<=0 for exactly the next cycle. It returns to 1 after that.
  - cfg_valid while cfg_ready=0 is not accepted; the requester holds it.
  - Write to a channel in the same cycle as its terminal bt: the write wins, and no tick or sq toggle occurs for that channel. Other channels tick normally.
  - The new settings apply to bt strobes from the cycle after acceptance.
- All widths are unsigned. period-1 is computed only when period!=0.
- rst asserted mid-operation returns everything to reset values immediately.

Test Plan:
- Reset/idle: assert rst mid-count with PRESCALE=4 -> all outputs 0 and cfg_ready=1 at once. With no start for 50 cycles -> base_tick and tick stay 0.
- Periodic run: PRESCALE=4; write ch0 period=3, en=1; pulse start in cycle 0.
  -> running=1 from cycle 1.
  -> base_tick high in cycles 5, 9, 13.
  -> tick[0] high in cycle 13, then every 12 cycles; sq[0] toggles with each tick.
- Multi-channel: ch0 period=1, ch1 period=2, ch2 period=0 en=1, ch3 period=2 en=0; RUN for 8 base ticks.
  -> tick[0] fires 8 times, tick[1] 4 times.
  -> tick[2] and tick[3] never fire.
- Stop/step: RUN; stop after ch0 (period=3) has counted 2 base ticks; then 1 step pulse in IDLE.
  -> tick[0] high the following cycle.
  -> running=0 throughout; pre_cnt stays 0.
- Start and stop in the same cycle from IDLE -> remains IDLE. Start and step in the same cycle -> one base tick, then RUN.
- Config collision: with cfg_valid held high, write ch0 in the cycle of its terminal bt.
  -> no tick[0] pulse; ch_cnt and sq cleared.
  -> cfg_ready low for one cycle; a second back-to-back write is accepted one cycle later.

Source files
------------

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: valid/ready channel-config port for tick_scheduler
interface tick_scheduler_if #(parameter int PER_W = 8);
    logic valid;
    logic ready;
    logic en;
    logic [1:0] ch;
    logic [PER_W-1:0] period;
    modport master(output valid, ch, en, period, input ready);
    modport slave(input valid, ch, en, period, output ready);
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler feeding four programmable tick/square channels
module tick_scheduler #(
    parameter int PRESCALE = 25000000,
    parameter int PRE_W = 25,
    parameter int PER_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    input  logic step,
    tick_scheduler_if.slave cfg,
    output logic running,
    output logic base_tick,
    output logic [3:0] tick,
    output logic [3:0] sq
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    state_t state, state_n;
    logic [PRE_W-1:0] pre_cnt;
    logic [PER_W-1:0] ch_cnt [4];
    logic [PER_W-1:0] period [4];
    logic [3:0] en, wsel, adv, fire;
    logic bt, wr;
    // start in RUN maps back to RUN, so only stop needs priority
    always_comb begin
        state_n = stop ? IDLE : (start ? RUN : state);
        bt = state == RUN ? pre_cnt == PRE_MAX : step;
        wr = cfg.valid && cfg.ready;
        wsel = '0;
        adv = '0;
        fire = '0;
        for (int c = 0; c < 4; c++) begin
            wsel[c] = wr && cfg.ch == 2'(c);
            adv[c] = bt && en[c] && period[c] != '0;
            fire[c] = adv[c] && ch_cnt[c] == period[c] - PER_W'(1);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            running <= 1'b0;
            pre_cnt <= '0;
            base_tick <= 1'b0;
            cfg.ready <= 1'b1;
        end else begin
            state <= state_n;
            running <= state_n == RUN;
            pre_cnt <= (state == RUN && state_n == RUN && pre_cnt != PRE_MAX) ? pre_cnt + PRE_W'(1) : '0;
            base_tick <= bt;
            cfg.ready <= !wr;
        end
    end
    // a config write to a channel overrides its terminal tick in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en <= '0;
            tick <= '0;
            sq <= '0;
            for (int c = 0; c < 4; c++) begin
                ch_cnt[c] <= '0;
                period[c] <= '0;
            end
        end else begin
            tick <= fire & ~wsel;
            sq <= (sq ^ fire) & ~wsel;
            for (int c = 0; c < 4; c++) begin
                if (wsel[c]) begin
                    period[c] <= cfg.period;
                    en[c] <= cfg.en;
                    ch_cnt[c] <= '0;
                end else if (adv[c]) begin
                    ch_cnt[c] <= fire[c] ? '0 : ch_cnt[c] + PER_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed self-checking bench for tick_scheduler (PRESCALE=4)
module tb_tick_scheduler;
    logic clk = 1'b0;
    logic rst, start, stop, step;
    logic running, base_tick;
    logic [3:0] tick, sq;
    int compared = 0;
    int mismatched = 0;
    int n0, n1, n2, n3;
    logic seen;
    tick_scheduler_if #(.PER_W(8)) cfg ();
    tick_scheduler #(.PRESCALE(4), .PRE_W(3), .PER_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .cfg(cfg),
        .running(running), .base_tick(base_tick), .tick(tick), .sq(sq)
    );
    always #5 clk = ~clk;
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wrcfg(input logic [1:0] ch, input logic en, input logic [7:0] per);
        cfg.valid = 1'b1;
        cfg.ch = ch;
        cfg.en = en;
        cfg.period = per;
        cyc();
        cfg.valid = 1'b0;
        chk("wr_ready_low", cfg.ready, 0);
        cyc();
        chk("wr_ready_back", cfg.ready, 1);
    endtask
    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
        cfg.valid = 1'b0; cfg.ch = 2'd0; cfg.en = 1'b0; cfg.period = 8'd0;
        repeat (2) cyc();
        chk("rst_running", running, 0);
        chk("rst_base_tick", base_tick, 0);
        chk("rst_tick", tick, 0);
        chk("rst_sq", sq, 0);
        chk("rst_ready", cfg.ready, 1);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cyc();
            seen = seen | base_tick | (|tick) | running;
        end
        chk("idle_quiet", seen, 0);
        chk("idle_pre_cnt", dut.pre_cnt, 0);
        // periodic run: ch0 period 3
        wrcfg(2'd0, 1'b1, 8'd3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int n = 1; n <= 28; n++) begin
            chk("run_running", running, 1);
            chk("run_base_tick", base_tick, (n >= 5 && (n - 5) % 4 == 0));
            chk("run_tick0", tick[0], (n == 13 || n == 25));
            chk("run_sq0", sq[0], (n >= 13 && n < 25));
            chk("run_tick_hi", tick[3:1], 0);
            cyc();
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_running", running, 0);
        // stop after two base ticks, then single step
        wrcfg(2'd0, 1'b1, 8'd3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (8) cyc();
        chk("ss_cnt2", dut.ch_cnt[0], 2);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("ss_running", running, 0);
        chk("ss_pre_cnt", dut.pre_cnt, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("ss_idle_running", running, 0);
            chk("ss_idle_pre_cnt", dut.pre_cnt, 0);
            chk("ss_idle_tick", tick, 0);
        end
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("step_tick0", tick[0], 1);
        chk("step_base_tick", base_tick, 1);
        chk("step_running", running, 0);
        chk("step_pre_cnt", dut.pre_cnt, 0);
        cyc();
        chk("step_tick_drop", tick, 0);
        chk("step_cnt", dut.ch_cnt[0], 0);
        chk("step_sq0", sq[0], 1);
        // multi-channel
        wrcfg(2'd0, 1'b1, 8'd1);
        wrcfg(2'd1, 1'b1, 8'd2);
        wrcfg(2'd2, 1'b1, 8'd0);
        wrcfg(2'd3, 1'b0, 8'd2);
        n0 = 0; n1 = 0; n2 = 0; n3 = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int m = 1; m <= 33; m++) begin
            n0 += int'(tick[0]); n1 += int'(tick[1]);
            n2 += int'(tick[2]); n3 += int'(tick[3]);
            cyc();
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("mc_tick0_count", n0, 8);
        chk("mc_tick1_count", n1, 4);
        chk("mc_tick2_count", n2, 0);
        chk("mc_tick3_count", n3, 0);
        chk("mc_sq", sq, 0);
        // start and stop together from IDLE
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("ss_both_running", running, 0);
        cyc();
        chk("ss_both_running2", running, 0);
        // start with step: one base tick, then RUN
        start = 1'b1; step = 1'b1;
        cyc();
        start = 1'b0; step = 1'b0;
        chk("stst_running", running, 1);
        chk("stst_base_tick", base_tick, 1);
        chk("stst_tick", tick, 4'b0001);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stst_stopped", running, 0);
        // config collision on ch0 terminal base tick
        wrcfg(2'd0, 1'b1, 8'd3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (9) cyc();
        cfg.valid = 1'b1; cfg.ch = 2'd1; cfg.en = 1'b1; cfg.period = 8'd5;
        cyc();
        chk("col_ready_m11", cfg.ready, 0);
        cfg.ch = 2'd0; cfg.en = 1'b1; cfg.period = 8'd3;
        cyc();
        chk("col_ready_m12", cfg.ready, 1);
        chk("col_cnt_before", dut.ch_cnt[0], 2);
        cyc();
        chk("col_tick", tick, 0);
        chk("col_sq0", sq[0], 0);
        chk("col_cnt_cleared", dut.ch_cnt[0], 0);
        chk("col_ready_m13", cfg.ready, 0);
        cfg.ch = 2'd2; cfg.en = 1'b1; cfg.period = 8'd4;
        cyc();
        chk("b2b_ready_m14", cfg.ready, 1);
        chk("b2b_not_yet", dut.period[2], 0);
        cyc();
        cfg.valid = 1'b0;
        chk("b2b_ready_m15", cfg.ready, 0);
        chk("b2b_period2", dut.period[2], 4);
        // async reset mid-run
        repeat (11) cyc();
        chk("pre_rst_sq0", sq[0], 1);
        chk("pre_rst_running", running, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_running", running, 0);
        chk("arst_base_tick", base_tick, 0);
        chk("arst_tick", tick, 0);
        chk("arst_sq", sq, 0);
        chk("arst_ready", cfg.ready, 1);
        chk("arst_pre_cnt", dut.pre_cnt, 0);
        chk("arst_cnt0", dut.ch_cnt[0], 0);
        cyc();
        rst = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
